spi_ram_ctrl: RTL and testbench

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
// ------------
// Memory back end for an SPI slave. Each accepted 10-bit command word carries
// a 2-bit opcode and an 8-bit payload:
//   00 : load the write pointer (rejected if the payload is outside the memory)
//   01 : store the payload at the write pointer, then advance it (wrapping)
//   10 : load the read pointer (rejected if the payload is outside the memory)
//   11 : return the word at the read pointer one cycle later, then advance it
// A data command issued before its pointer has been validly loaded is
// rejected with an err pulse. The write and read pointers are fully
// independent.
//
// Parameters
//   MEM_DEPTH : number of 8-bit words in the memory
//   ADDR_SIZE : width of the write/read pointers
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous, active-high reset (memory contents are kept)
//   din      : command word, [9:8] opcode, [7:0] payload
//   rx_valid : din is valid this cycle
//   dout     : read data, held until the next accepted read
//   tx_valid : one-cycle pulse, dout carries fresh read data
//   err      : one-cycle pulse, the previous command was rejected

module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = ADDR_SIZE'(1);

  logic [7:0]           mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wa_ok;
  logic                 ra_ok;

  opcode_t              opcode;
  logic [7:0]           payload;
  logic                 payload_in_range;
  logic                 mem_we;

  assign opcode  = opcode_t'(din[9:8]);
  assign payload = din[7:0];

  // The payload is compared at full integer width so that a depth of 256
  // (every 8-bit payload legal) and smaller depths are handled alike.
  assign payload_in_range = ({24'b0, payload} < 32'(MEM_DEPTH));

  // Reset wins over a simultaneous command, so the store is gated by it too.
  assign mem_we = !rst && rx_valid && (opcode == OP_WR_DATA) && wa_ok;

  // Pointer advance with wrap at the last implemented word, which need not
  // be a power of two.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] addr);
    next_addr = (addr == LAST_ADDR) ? '0 : addr + ONE_ADDR;
  endfunction

  // Storage array. Deliberately has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= payload;
    end
  end

  // Command decode and pointer/flag state. tx_valid and err are pulses, so
  // they default low every cycle and are only raised by the command that
  // causes them; dout is left alone unless a read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wa_ok    <= 1'b0;
      ra_ok    <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      err      <= 1'b0;
      if (rx_valid) begin
        case (opcode)
          OP_WR_ADDR: begin
            if (payload_in_range) begin
              wr_addr <= ADDR_SIZE'(payload);
              wa_ok   <= 1'b1;
            end else begin
              wa_ok <= 1'b0;
              err   <= 1'b1;
            end
          end
          OP_WR_DATA: begin
            if (wa_ok) begin
              wr_addr <= next_addr(wr_addr);
            end else begin
              err <= 1'b1;
            end
          end
          OP_RD_ADDR: begin
            if (payload_in_range) begin
              rd_addr <= ADDR_SIZE'(payload);
              ra_ok   <= 1'b1;
            end else begin
              ra_ok <= 1'b0;
              err   <= 1'b1;
            end
          end
          OP_RD_DATA: begin
            if (ra_ok) begin
              dout     <= mem[rd_addr];
              tx_valid <= 1'b1;
              rd_addr  <= next_addr(rd_addr);
            end else begin
              err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl
// ---------------
// Self-checking bench for spi_ram_ctrl. Two instances are exercised: one at
// the default depth of 256 words and one at 200 words, so that out-of-range
// pointer loads can be provoked. Each bench cycle drives one command into one
// instance and compares dout/tx_valid/err of both instances against a
// behavioural reference model of the command rules.
//
// Ports: none (top-level bench).

module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst      [2];
  logic [9:0] din      [2];
  logic       rx_valid [2];
  logic [7:0] dout     [2];
  logic       tx_valid [2];
  logic       err      [2];

  int vectors;
  int miscompares;

  // Reference model state, one set per instance.
  int         m_depth   [2];
  logic [7:0] m_mem     [2][256];
  int         m_wr      [2];
  int         m_rd      [2];
  bit         m_wa_ok   [2];
  bit         m_ra_ok   [2];
  logic [7:0] m_dout    [2];
  bit         m_tx      [2];
  bit         m_err     [2];

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_full (
    .clk      (clk),
    .rst      (rst[0]),
    .din      (din[0]),
    .rx_valid (rx_valid[0]),
    .dout     (dout[0]),
    .tx_valid (tx_valid[0]),
    .err      (err[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_small (
    .clk      (clk),
    .rst      (rst[1]),
    .din      (din[1]),
    .rx_valid (rx_valid[1]),
    .dout     (dout[1]),
    .tx_valid (tx_valid[1]),
    .err      (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one instance's model by one clock edge from its sampled inputs.
  function automatic void modelStep(input int k, input bit r, input bit v, input logic [9:0] w);
    int p;
    p = int'(w[7:0]);
    if (r) begin
      m_dout[k]  = 8'h00;
      m_tx[k]    = 1'b0;
      m_err[k]   = 1'b0;
      m_wr[k]    = 0;
      m_rd[k]    = 0;
      m_wa_ok[k] = 1'b0;
      m_ra_ok[k] = 1'b0;
      return;
    end
    m_tx[k]  = 1'b0;
    m_err[k] = 1'b0;
    if (!v) return;
    case (w[9:8])
      2'b00: begin
        if (p < m_depth[k]) begin
          m_wr[k] = p;
          m_wa_ok[k] = 1'b1;
        end else begin
          m_wa_ok[k] = 1'b0;
          m_err[k] = 1'b1;
        end
      end
      2'b01: begin
        if (m_wa_ok[k]) begin
          m_mem[k][m_wr[k]] = w[7:0];
          m_wr[k] = (m_wr[k] + 1) % m_depth[k];
        end else begin
          m_err[k] = 1'b1;
        end
      end
      2'b10: begin
        if (p < m_depth[k]) begin
          m_rd[k] = p;
          m_ra_ok[k] = 1'b1;
        end else begin
          m_ra_ok[k] = 1'b0;
          m_err[k] = 1'b1;
        end
      end
      default: begin
        if (m_ra_ok[k]) begin
          m_dout[k] = m_mem[k][m_rd[k]];
          m_tx[k] = 1'b1;
          m_rd[k] = (m_rd[k] + 1) % m_depth[k];
        end else begin
          m_err[k] = 1'b1;
        end
      end
    endcase
  endfunction

  // Compare one instance's outputs with the model.
  task automatic checkOutput(input int k, input string tag);
    vectors++;
    assert (dout[k] === m_dout[k]) else begin
      miscompares++;
      $error("[TB] FAIL %s inst%0d dout: got %h expected %h", tag, k, dout[k], m_dout[k]);
    end
    vectors++;
    assert (tx_valid[k] === m_tx[k]) else begin
      miscompares++;
      $error("[TB] FAIL %s inst%0d tx_valid: got %b expected %b", tag, k, tx_valid[k], m_tx[k]);
    end
    vectors++;
    assert (err[k] === m_err[k]) else begin
      miscompares++;
      $error("[TB] FAIL %s inst%0d err: got %b expected %b", tag, k, err[k], m_err[k]);
    end
  endtask

  // One clock cycle: drive instance k (the other idles), step both models,
  // then check both instances shortly after the edge.
  task automatic applyStimulus(input int k, input bit r, input bit v, input logic [9:0] w,
                               input string tag);
    for (int i = 0; i < 2; i++) begin
      rst[i]      = (i == k) ? r : 1'b0;
      rx_valid[i] = (i == k) ? v : 1'b0;
      din[i]      = (i == k) ? w : 10'h000;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i, rst[i], rx_valid[i], din[i]);
    #1;
    checkOutput(0, tag);
    checkOutput(1, tag);
  endtask

  task automatic resetBoth();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      rx_valid[i] = 1'b0;
      din[i] = 10'h000;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i, 1'b1, 1'b0, 10'h000);
    #1;
    checkOutput(0, "reset");
    checkOutput(1, "reset");
  endtask

  task automatic cmd(input int k, input logic [1:0] op, input logic [7:0] p, input string tag);
    applyStimulus(k, 1'b0, 1'b1, {op, p}, tag);
  endtask

  task automatic idle(input int k, input string tag);
    applyStimulus(k, 1'b0, 1'b0, 10'h000, tag);
  endtask

  // Fill every word of instance k with random data so later reads are defined.
  task automatic fillMemory(input int k);
    cmd(k, 2'b00, 8'h00, "fill_addr");
    for (int a = 0; a < m_depth[k]; a++) begin
      cmd(k, 2'b01, 8'($urandom), "fill_data");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_depth[0]  = 256;
    m_depth[1]  = 200;
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = 8'h00;
      m_tx[i] = 1'b0;
      m_err[i] = 1'b0;
      for (int a = 0; a < 256; a++) m_mem[i][a] = 8'h00;
    end

    $display("[TB] reset and early read rejection");
    resetBoth();
    cmd(0, 2'b11, 8'h00, "read_after_reset");
    idle(0, "err_clears");
    cmd(0, 2'b01, 8'h77, "write_after_reset");

    $display("[TB] initialising memories");
    fillMemory(0);
    fillMemory(1);

    $display("[TB] basic write then read");
    cmd(0, 2'b00, 8'h10, "basic_wa");
    cmd(0, 2'b01, 8'hA5, "basic_wd");
    cmd(0, 2'b10, 8'h10, "basic_ra");
    cmd(0, 2'b11, 8'h00, "basic_rd");
    idle(0, "basic_tx_clears");
    idle(0, "basic_dout_holds");

    $display("[TB] burst with pointer wrap");
    cmd(0, 2'b00, 8'hFE, "burst_wa");
    cmd(0, 2'b01, 8'h11, "burst_wd0");
    cmd(0, 2'b01, 8'h22, "burst_wd1");
    cmd(0, 2'b01, 8'h33, "burst_wd2");
    cmd(0, 2'b10, 8'hFE, "burst_ra");
    cmd(0, 2'b11, 8'h00, "burst_rd0");
    cmd(0, 2'b11, 8'h5C, "burst_rd1");
    cmd(0, 2'b11, 8'hFF, "burst_rd2");
    idle(0, "burst_end");

    $display("[TB] out-of-range pointer on small instance");
    cmd(1, 2'b00, 8'hC8, "oor_wa");
    cmd(1, 2'b01, 8'h55, "oor_wd");
    cmd(1, 2'b10, 8'hC8, "oor_ra");
    cmd(1, 2'b11, 8'h00, "oor_rd_rejected");
    cmd(1, 2'b10, 8'h00, "oor_check_ra");
    cmd(1, 2'b11, 8'h00, "oor_check_rd");
    cmd(1, 2'b00, 8'hC7, "edge_wa");
    cmd(1, 2'b01, 8'h9E, "edge_wd");
    cmd(1, 2'b01, 8'h4B, "edge_wd_wrap");
    cmd(1, 2'b10, 8'hC7, "edge_ra");
    cmd(1, 2'b11, 8'h00, "edge_rd");
    cmd(1, 2'b11, 8'h00, "edge_rd_wrap");

    $display("[TB] reset during a command");
    cmd(0, 2'b00, 8'h03, "rst_wa");
    cmd(0, 2'b01, 8'h5A, "rst_wd");
    applyStimulus(0, 1'b1, 1'b1, {2'b01, 8'hFF}, "rst_with_cmd");
    cmd(0, 2'b10, 8'h03, "rst_ra");
    cmd(0, 2'b11, 8'h00, "rst_rd");

    $display("[TB] read immediately after write");
    cmd(0, 2'b00, 8'h40, "raw_wa");
    cmd(0, 2'b01, 8'hC3, "raw_wd");
    cmd(0, 2'b10, 8'h40, "raw_ra");
    cmd(0, 2'b11, 8'h00, "raw_rd");
    cmd(0, 2'b00, 8'h41, "raw2_wa");
    cmd(0, 2'b10, 8'h41, "raw2_ra");
    cmd(0, 2'b01, 8'h3C, "raw2_wd");
    cmd(0, 2'b11, 8'h00, "raw2_rd");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      int k;
      int sel;
      bit r;
      bit v;
      k   = (n % 3 == 2) ? 1 : 0;
      sel = int'($urandom_range(0, 39));
      r   = (sel == 0);
      v   = (sel > 4);
      applyStimulus(k, r, v, 10'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
